// File: rtl/rotate_sequencer.sv
// rotate_sequencer: start/busy/done engine applying one single-position rotate per enabled cycle.
module rotate_sequencer #(
  parameter int WIDTH = 4,
  parameter int AMT_W = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] din,
  input  logic [AMT_W-1:0] amt,
  input  logic             dir,
  input  logic             en,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] dout
);
  typedef enum logic [1:0] {IDLE, ROT, DONE} state_t;
  state_t           r_state, w_next;
  logic [WIDTH-1:0] r_dout, w_step;
  logic [AMT_W-1:0] r_cnt;
  logic             r_dir;
  logic             w_accept, w_step_en;
  assign w_accept  = (r_state == IDLE) && start;
  assign w_step_en = (r_state == ROT) && en;
  assign w_step    = r_dir ? {r_dout[WIDTH-2:0], r_dout[WIDTH-1]} : {r_dout[0], r_dout[WIDTH-1:1]};
  always_comb begin
    w_next = IDLE;
    if (r_state == IDLE) w_next = start ? ((amt == '0) ? DONE : ROT) : IDLE;
    else if (r_state == ROT) w_next = (en && r_cnt == AMT_W'(1)) ? DONE : ROT;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_dout  <= '0;
      r_cnt   <= '0;
      r_dir   <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_dout <= din;
        r_cnt  <= amt;
        r_dir  <= dir;
      end else if (w_step_en) begin
        r_dout <= w_step;
        r_cnt  <= r_cnt - AMT_W'(1);
      end
    end
  end
  assign ready = (r_state == IDLE);
  assign busy  = (r_state == ROT);
  assign done  = (r_state == DONE);
  assign dout  = r_dout;
endmodule

// File: tb/tb_rotate_sequencer.sv
// tb_rotate_sequencer: directed self-checking bench for rotate_sequencer.
module tb_rotate_sequencer;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [3:0] din = 4'b0;
  logic [1:0] amt = 2'b0;
  logic       dir = 1'b0;
  logic       en = 1'b1;
  logic       ready, busy, done;
  logic [3:0] dout;
  int         tests = 0;
  int         fails = 0;

  rotate_sequencer #(.WIDTH(4), .AMT_W(2)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .din(din), .amt(amt), .dir(dir),
    .en(en), .ready(ready), .busy(busy), .done(done), .dout(dout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    chk("onehot", {30'b0, ready} + {30'b0, busy} + {30'b0, done}, 1);
  endtask

  task automatic st(input string tag, input logic r, input logic b, input logic d, input logic [3:0] o);
    chk({tag, ".ready"}, r, r);
    chk({tag, ".ready"}, ready, r);
    chk({tag, ".busy"}, busy, b);
    chk({tag, ".done"}, done, d);
    chk({tag, ".dout"}, dout, o);
  endtask

  task automatic go(input logic [3:0] d, input logic [1:0] a, input logic r);
    start = 1'b1; din = d; amt = a; dir = r;
    tick();
    start = 1'b0;
  endtask

  initial begin
    start = 1'b1; din = 4'b1111;
    tick();
    st("reset", 1, 0, 0, 4'b0000);
    tick();
    st("reset_hold", 1, 0, 0, 4'b0000);
    start = 1'b0;
    rst_n = 1'b1;
    tick();
    st("post_reset", 1, 0, 0, 4'b0000);

    go(4'b1100, 2'd1, 1'b0);
    st("s1r_e0", 0, 1, 0, 4'b1100);
    tick();
    st("s1r_done", 0, 0, 1, 4'b0110);
    tick();
    st("s1r_idle", 1, 0, 0, 4'b0110);
    go(4'b0110, 2'd1, 1'b1);
    tick();
    st("s1l_done", 0, 0, 1, 4'b1100);
    tick();

    go(4'b1100, 2'd3, 1'b0);
    st("m3r_e0", 0, 1, 0, 4'b1100);
    tick();
    st("m3r_e1", 0, 1, 0, 4'b0110);
    tick();
    st("m3r_e2", 0, 1, 0, 4'b0011);
    tick();
    st("m3r_done", 0, 0, 1, 4'b1001);
    tick();
    st("m3r_idle", 1, 0, 0, 4'b1001);
    go(4'b1100, 2'd3, 1'b1);
    tick();
    st("m3l_e1", 0, 1, 0, 4'b1001);
    tick();
    tick();
    st("m3l_done", 0, 0, 1, 4'b0110);
    tick();

    start = 1'b1; din = 4'b1010; amt = 2'd0; dir = 1'b0;
    tick();
    st("z_done", 0, 0, 1, 4'b1010);
    din = 4'b0011; amt = 2'd1; dir = 1'b1;
    tick();
    st("b2b_idle", 1, 0, 0, 4'b1010);
    tick();
    start = 1'b0;
    st("b2b_e0", 0, 1, 0, 4'b0011);
    tick();
    st("b2b_done", 0, 0, 1, 4'b0110);
    tick();

    go(4'b0001, 2'd2, 1'b1);
    tick();
    st("stall_e1", 0, 1, 0, 4'b0010);
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      st("stall", 0, 1, 0, 4'b0010);
    end
    en = 1'b1;
    tick();
    st("stall_done", 0, 0, 1, 4'b0100);
    tick();

    go(4'b1011, 2'd2, 1'b0);
    start = 1'b1; din = 4'b0000; amt = 2'd3; dir = 1'b1;
    tick();
    st("iso_e1", 0, 1, 0, 4'b1101);
    din = 4'b1111; amt = 2'd1; dir = 1'b0;
    tick();
    start = 1'b0;
    st("iso_done", 0, 0, 1, 4'b1110);
    for (int i = 0; i < 3; i++) begin
      tick();
      st("iso_idle", 1, 0, 0, 4'b1110);
    end

    go(4'b1100, 2'd3, 1'b0);
    tick();
    st("abort_e1", 0, 1, 0, 4'b0110);
    #2 rst_n = 1'b0;
    #1;
    st("abort", 1, 0, 0, 4'b0000);
    #2 rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      st("abort_after", 1, 0, 0, 4'b0000);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
